// File: rtl/cpu_sequencer.sv
// Control sequencer for a small accumulator CPU: fetch, decode, operand fetch and execute,
// driving datapath strobes combinationally from the current state and live inputs.
module cpu_sequencer #(
   parameter int word_size = 8
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic [3:0] opcode,
   input  logic       zero_flag,
   input  logic       mem_ready,
   output logic       sel_pc,
   output logic       load_addr,
   output logic       load_ir,
   output logic       load_pc,
   output logic       inc_pc,
   output logic       mem_rd,
   output logic       mem_wr,
   output logic       load_acc,
   output logic [2:0] alu_op,
   output logic       halted,
   output logic       err,
   output logic [2:0] state
);

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      FETCH_A = 3'd1,
      FETCH_M = 3'd2,
      DECODE  = 3'd3,
      OPND_A  = 3'd4,
      OPND_M  = 3'd5,
      EXEC    = 3'd6,
      HALT    = 3'd7
   } state_t;

   localparam logic [3:0] OP_NOP = 4'h0;
   localparam logic [3:0] OP_ADD = 4'h1;
   localparam logic [3:0] OP_SUB = 4'h2;
   localparam logic [3:0] OP_AND = 4'h3;
   localparam logic [3:0] OP_NOT = 4'h4;
   localparam logic [3:0] OP_WR  = 4'h6;
   localparam logic [3:0] OP_BR  = 4'h7;
   localparam logic [3:0] OP_BRZ = 4'h8;
   localparam logic [3:0] OP_HLT = 4'hF;

   // The opcode is the top nibble of the instruction word, so the word must hold one.
   generate
      if (word_size < 4) begin : g_word_size_check
         $error("cpu_sequencer: word_size must be at least 4");
      end
   endgenerate

   state_t state_reg;
   state_t state_next;
   logic   err_reg;
   logic   err_next;
   logic   op_illegal;
   logic   op_branch;

   assign op_illegal = (opcode >= 4'h9) && (opcode <= 4'hE);
   assign op_branch  = (opcode == OP_BR) || (opcode == OP_BRZ);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_reg <= IDLE;
         err_reg   <= 1'b0;
      end else begin
         state_reg <= state_next;
         err_reg   <= err_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      err_next   = err_reg;
      case (state_reg)
         IDLE:    if (start) state_next = FETCH_A;
         FETCH_A: state_next = FETCH_M;
         FETCH_M: if (mem_ready) state_next = DECODE;
         DECODE: begin
            if (opcode == OP_NOP || opcode == OP_NOT) begin
               state_next = FETCH_A;
            end else if (opcode == OP_HLT) begin
               state_next = HALT;
            end else if (op_illegal) begin
               state_next = HALT;
               err_next   = 1'b1;
            end else if (opcode == OP_BRZ && !zero_flag) begin
               state_next = FETCH_A;
            end else begin
               state_next = OPND_A;
            end
         end
         OPND_A:  state_next = OPND_M;
         OPND_M:  if (mem_ready) state_next = op_branch ? FETCH_A : EXEC;
         EXEC:    if (mem_ready) state_next = FETCH_A;
         HALT:    state_next = HALT;
         default: state_next = IDLE;
      endcase
   end

   always_comb begin
      sel_pc    = 1'b0;
      load_addr = 1'b0;
      load_ir   = 1'b0;
      load_pc   = 1'b0;
      inc_pc    = 1'b0;
      mem_rd    = 1'b0;
      mem_wr    = 1'b0;
      load_acc  = 1'b0;
      alu_op    = 3'd0;
      halted    = 1'b0;
      case (state_reg)
         FETCH_A, OPND_A: begin
            sel_pc    = 1'b1;
            load_addr = 1'b1;
         end
         FETCH_M: begin
            mem_rd  = 1'b1;
            load_ir = mem_ready;
            inc_pc  = mem_ready;
         end
         DECODE: begin
            if (opcode == OP_NOT) begin
               load_acc = 1'b1;
               alu_op   = 3'd4;
            end
            // A not-taken BRZ steps over its operand byte.
            if (opcode == OP_BRZ && !zero_flag) inc_pc = 1'b1;
         end
         OPND_M: begin
            mem_rd = 1'b1;
            if (mem_ready) begin
               if (op_branch) begin
                  load_pc = 1'b1;
               end else begin
                  load_addr = 1'b1;
                  inc_pc    = 1'b1;
               end
            end
         end
         EXEC: begin
            if (opcode == OP_WR) begin
               mem_wr = 1'b1;
            end else begin
               mem_rd   = 1'b1;
               load_acc = mem_ready;
               if (mem_ready) begin
                  case (opcode)
                     OP_ADD:  alu_op = 3'd1;
                     OP_SUB:  alu_op = 3'd2;
                     OP_AND:  alu_op = 3'd3;
                     default: alu_op = 3'd0;
                  endcase
               end
            end
         end
         HALT:    halted = 1'b1;
         default: ;
      endcase
   end

   assign err   = err_reg;
   assign state = state_reg;

endmodule

// File: tb/tb_cpu_sequencer.sv
// Randomized scoreboard bench for cpu_sequencer: per-cycle expected outputs are derived
// from instruction-level rules and compared by an independent negedge monitor.
module tb_cpu_sequencer;

   typedef struct packed {
      logic [2:0] state;
      logic       sel_pc;
      logic       load_addr;
      logic       load_ir;
      logic       load_pc;
      logic       inc_pc;
      logic       mem_rd;
      logic       mem_wr;
      logic       load_acc;
      logic [2:0] alu_op;
      logic       halted;
      logic       err;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       start = 1'b0;
   logic [3:0] opcode = 4'h0;
   logic       zero_flag = 1'b0;
   logic       mem_ready = 1'b0;
   logic       sel_pc, load_addr, load_ir, load_pc, inc_pc, mem_rd, mem_wr, load_acc;
   logic [2:0] alu_op;
   logic       halted, err;
   logic [2:0] state;

   int   checks = 0;
   int   errors = 0;
   int   n_instr = 0;
   bit   zero_wait = 1'b0;
   exp_t exp_q[$];
   exp_t mon_e;
   exp_t mon_g;

   cpu_sequencer #(.word_size(8)) dut (
      .clk(clk), .rst(rst), .start(start), .opcode(opcode), .zero_flag(zero_flag),
      .mem_ready(mem_ready), .sel_pc(sel_pc), .load_addr(load_addr), .load_ir(load_ir),
      .load_pc(load_pc), .inc_pc(inc_pc), .mem_rd(mem_rd), .mem_wr(mem_wr),
      .load_acc(load_acc), .alu_op(alu_op), .halted(halted), .err(err), .state(state)
   );

   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("FAIL watchdog expired checks=%0d", checks);
      $fatal(1, "watchdog");
   end

   function automatic exp_t sample();
      exp_t g;
      g.state = state; g.sel_pc = sel_pc; g.load_addr = load_addr; g.load_ir = load_ir;
      g.load_pc = load_pc; g.inc_pc = inc_pc; g.mem_rd = mem_rd; g.mem_wr = mem_wr;
      g.load_acc = load_acc; g.alu_op = alu_op; g.halted = halted; g.err = err;
      return g;
   endfunction

   function automatic exp_t blank(input logic [2:0] st);
      exp_t e;
      e = '0;
      e.state = st;
      return e;
   endfunction

   // Monitor: one expected output vector per clock while out of reset.
   always @(negedge clk) begin
      if (rst && exp_q.size() > 0) begin
         mon_e = exp_q.pop_front();
         mon_g = sample();
         checks++;
         if (mon_g !== mon_e) begin
            errors++;
            $display("FAIL cycle_out t=%0t instr=%0d got state=%0d vec=%h required state=%0d vec=%h",
                     $time, n_instr, mon_g.state, mon_g, mon_e.state, mon_e);
         end
      end
   end

   task automatic chk(input string name, input int got, input int req);
      checks++;
      if (got !== req) begin
         errors++;
         $display("FAIL %s got %0d required %0d", name, got, req);
      end
   endtask

   task automatic cyc(input exp_t e, input logic mr);
      mem_ready = mr;
      exp_q.push_back(e);
      @(posedge clk);
      #1;
   endtask

   task automatic cyc_any(input exp_t e);
      cyc(e, 1'($urandom_range(0, 1)));
   endtask

   task automatic mem_phase(input exp_t wait_e, input exp_t done_e, input int waits);
      int w;
      if (waits >= 0) w = waits;
      else if (zero_wait || $urandom_range(0, 1) == 0) w = 0;
      else w = int'($urandom_range(1, 3));
      for (int i = 0; i < w; i++) cyc(wait_e, 1'b0);
      cyc(done_e, 1'b1);
   endtask

   // Expected cycle trace of one instruction, starting in FETCH_A.
   task automatic run_instr(input logic [3:0] op, input logic z, input int exec_waits);
      exp_t e, w, d;
      bit   branch, illegal;
      n_instr++;
      $display("INSTR %0d op=%h zero_flag=%0b", n_instr, op, z);
      opcode = op;
      zero_flag = z;
      start = 1'($urandom_range(0, 1));
      branch  = (op == 4'h7) || (op == 4'h8);
      illegal = (op >= 4'h9) && (op <= 4'hE);
      e = blank(3'd1); e.sel_pc = 1'b1; e.load_addr = 1'b1;
      cyc_any(e);
      w = blank(3'd2); w.mem_rd = 1'b1;
      d = w; d.load_ir = 1'b1; d.inc_pc = 1'b1;
      mem_phase(w, d, -1);
      e = blank(3'd3);
      if (op == 4'h0 || op == 4'hF || illegal) begin
         cyc_any(e);
         return;
      end
      if (op == 4'h4) begin
         e.load_acc = 1'b1; e.alu_op = 3'd4;
         cyc_any(e);
         return;
      end
      if (op == 4'h8 && !z) begin
         e.inc_pc = 1'b1;
         cyc_any(e);
         return;
      end
      cyc_any(e);
      e = blank(3'd4); e.sel_pc = 1'b1; e.load_addr = 1'b1;
      cyc_any(e);
      w = blank(3'd5); w.mem_rd = 1'b1;
      d = w;
      if (branch) d.load_pc = 1'b1;
      else begin d.load_addr = 1'b1; d.inc_pc = 1'b1; end
      mem_phase(w, d, -1);
      if (branch) return;
      w = blank(3'd6);
      if (op == 4'h6) begin
         w.mem_wr = 1'b1;
         d = w;
      end else begin
         w.mem_rd = 1'b1;
         d = w; d.load_acc = 1'b1;
         d.alu_op = (op == 4'h1) ? 3'd1 : (op == 4'h2) ? 3'd2 : (op == 4'h3) ? 3'd3 : 3'd0;
      end
      mem_phase(w, d, exec_waits);
   endtask

   task automatic halt_cycles(input logic err_req, input int n);
      exp_t e;
      e = blank(3'd7); e.halted = 1'b1; e.err = err_req;
      for (int i = 0; i < n; i++) begin
         start = 1'($urandom_range(0, 1));
         cyc_any(e);
      end
   endtask

   // Reset mid-cycle with no clock edge in between, then leave IDLE idle for a while.
   task automatic async_reset(input string name);
      exp_t g;
      #1 rst = 1'b0;
      #1 g = sample();
      chk({name, "_state"}, int'(g.state), 0);
      chk({name, "_err"}, int'(g.err), 0);
      chk({name, "_outputs"}, int'(g), 0);
      @(posedge clk); #1;
      rst = 1'b1;
      start = 1'b0;
      for (int i = 0; i < 3; i++) cyc_any(blank(3'd0));
   endtask

   task automatic kick();
      start = 1'b1;
      cyc_any(blank(3'd0));
      start = 1'b0;
   endtask

   initial begin
      exp_t g;
      #1 g = sample();
      chk("reset_outputs", int'(g), 0);
      @(posedge clk); #1;
      rst = 1'b1;
      for (int i = 0; i < 3; i++) cyc_any(blank(3'd0));
      kick();

      zero_wait = 1'b1;
      run_instr(4'h0, 1'b0, 0);
      run_instr(4'h0, 1'b1, 0);
      run_instr(4'h1, 1'b0, 0);
      run_instr(4'h8, 1'b1, 0);
      run_instr(4'h8, 1'b0, 0);
      run_instr(4'h4, 1'b0, 0);
      zero_wait = 1'b0;
      run_instr(4'h6, 1'b0, 4);

      for (int i = 0; i < 150; i++)
         run_instr(4'($urandom_range(0, 8)), 1'($urandom_range(0, 1)), -1);

      run_instr(4'hF, 1'b0, -1);
      halt_cycles(1'b0, 4);
      async_reset("hlt_reset");

      kick();
      cyc_any(blank(3'd1) | exp_t'({3'd0, 2'b11, 11'd0}));
      mem_ready = 1'b0;
      g = sample();
      chk("fetch_m_state", int'(g.state), 2);
      chk("fetch_m_mem_rd", int'(g.mem_rd), 1);
      async_reset("fetch_m_reset");

      kick();
      run_instr(4'hA, 1'b1, -1);
      halt_cycles(1'b1, 5);
      async_reset("illegal_reset");

      kick();
      run_instr(4'($urandom_range(9, 14)), 1'b0, -1);
      halt_cycles(1'b1, 3);
      async_reset("illegal2_reset");

      @(negedge clk); #1;
      chk("queue_drained", exp_q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
